// File: rtl/mmc5_xram_arb.sv
// MMC5 ExRAM arbiter: one single-port synchronous RAM shared by save-state,
// PPU fetch and CPU window, with at most one granted access per clk.
//
// state    | meaning
// IDLE     | no grant was issued last cycle
// OWN_SS   | save-state granted last cycle (ss_ack high now)
// OWN_PPU  | PPU granted last cycle (ppu_ack high now)
// OWN_CPU  | CPU granted last cycle (cpu_ack high now)
module mmc5_xram_arb #(
    parameter int CPU_MAX_WAIT = 6,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          map_rst_n,
    input  logic [1:0]    exram_mode,
    input  logic          ss_act,
    input  logic          ss_req,
    input  logic          ss_we,
    input  logic [AW-1:0] ss_addr,
    input  logic [7:0]    ss_wdat,
    output logic          ss_ack,
    output logic          ss_rvalid,
    input  logic          ppu_req,
    input  logic          ppu_we,
    input  logic [AW-1:0] ppu_addr,
    input  logic [7:0]    ppu_wdat,
    output logic          ppu_ack,
    output logic          ppu_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdat,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [7:0]    rd_dat,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout
);

    localparam int WW = $clog2(CPU_MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, OWN_SS, OWN_PPU, OWN_CPU} own_t;

    own_t          state, state_nxt;
    own_t          rd1_own;
    logic          rd1_zero, rd2_zero;
    logic [WW-1:0] wait_ctr, wait_nxt;

    logic          ss_elig, ppu_elig, cpu_elig, cpu_promote;
    logic [AW-1:0] g_addr;
    logic [7:0]    g_wdat;
    logic          g_we, g_rd, g_zero;

    // The ack is simply "who owned the RAM last cycle"
    assign ss_ack  = (state == OWN_SS);
    assign ppu_ack = (state == OWN_PPU);
    assign cpu_ack = (state == OWN_CPU);

    assign ss_elig     = ss_act && ss_req && !ss_ack;
    assign ppu_elig    = !ss_act && ppu_req && !ppu_ack;
    assign cpu_elig    = !ss_act && cpu_req && !cpu_ack;
    assign cpu_promote = (wait_ctr >= WW'(CPU_MAX_WAIT));

    always_comb begin
        state_nxt = IDLE;
        if (ss_elig)
            state_nxt = OWN_SS;
        else if (cpu_elig && cpu_promote)
            state_nxt = OWN_CPU;
        else if (ppu_elig)
            state_nxt = OWN_PPU;
        else if (cpu_elig)
            state_nxt = OWN_CPU;
    end

    // Frozen for the whole save-state session so CPU starvation credit survives it
    always_comb begin
        wait_nxt = wait_ctr;
        if (!ss_act) begin
            if (!cpu_req || state_nxt == OWN_CPU)
                wait_nxt = '0;
            else if (cpu_elig && !cpu_promote)
                wait_nxt = wait_ctr + WW'(1);
        end
    end

    always_comb begin
        g_addr = '0;
        g_wdat = '0;
        g_we   = 1'b0;
        g_rd   = 1'b0;
        g_zero = 1'b0;
        case (state_nxt)
            OWN_SS: begin
                g_addr = ss_addr;
                g_wdat = ss_wdat;
                g_we   = ss_we;
                g_rd   = !ss_we;
            end
            OWN_PPU: begin
                g_addr = ppu_addr;
                g_wdat = ppu_wdat;
                g_we   = ppu_we && !exram_mode[1];
                g_rd   = !ppu_we;
            end
            OWN_CPU: begin
                g_addr = cpu_addr;
                g_wdat = cpu_wdat;
                g_we   = cpu_we && (exram_mode != 2'd3);
                g_rd   = !cpu_we;
                g_zero = !exram_mode[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            state    <= IDLE;
            wait_ctr <= '0;
        end else begin
            state    <= state_nxt;
            wait_ctr <= wait_nxt;
        end
    end

    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_we     <= 1'b0;
            rd1_own    <= IDLE;
            rd1_zero   <= 1'b0;
            rd2_zero   <= 1'b0;
            ss_rvalid  <= 1'b0;
            ppu_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else begin
            ram_we <= g_we;
            if (state_nxt != IDLE) begin
                ram_addr <= g_addr;
                ram_din  <= g_wdat;
            end
            rd1_own    <= g_rd ? state_nxt : IDLE;
            rd1_zero   <= g_rd && g_zero;
            rd2_zero   <= rd1_zero;
            ss_rvalid  <= (rd1_own == OWN_SS);
            ppu_rvalid <= (rd1_own == OWN_PPU);
            cpu_rvalid <= (rd1_own == OWN_CPU);
        end
    end

    // RAM data arrives the cycle after the address, i.e. alongside the rvalid
    assign rd_dat = ((ss_rvalid || ppu_rvalid || cpu_rvalid) && !rd2_zero) ? ram_dout : 8'h00;

endmodule

// File: tb/tb_mmc5_xram_arb.sv
// Bench for mmc5_xram_arb: directed requests, a behavioural RAM, and a
// slot-scheduled reference model checked on every falling clock edge.
module tb_mmc5_xram_arb;

    localparam int MAXW = 6;

    logic       clk = 1'b0;
    logic       map_rst_n;
    logic [1:0] exram_mode;
    logic       ss_act, ss_req, ss_we;
    logic [9:0] ss_addr;
    logic [7:0] ss_wdat;
    logic       ss_ack, ss_rvalid;
    logic       ppu_req, ppu_we;
    logic [9:0] ppu_addr;
    logic [7:0] ppu_wdat;
    logic       ppu_ack, ppu_rvalid;
    logic       cpu_req, cpu_we;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_wdat;
    logic       cpu_ack, cpu_rvalid;
    logic [7:0] rd_dat;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    logic       pl_en = 1'b0;
    logic [9:0] pl_addr = '0;
    logic [7:0] pl_dat = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int rst_pulses = 0;

    always #5 clk = ~clk;

    mmc5_xram_arb #(.CPU_MAX_WAIT(MAXW), .AW(10)) dut (
        .clk(clk), .map_rst_n(map_rst_n), .exram_mode(exram_mode),
        .ss_act(ss_act), .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr),
        .ss_wdat(ss_wdat), .ss_ack(ss_ack), .ss_rvalid(ss_rvalid),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr),
        .ppu_wdat(ppu_wdat), .ppu_ack(ppu_ack), .ppu_rvalid(ppu_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdat(cpu_wdat), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
        .rd_dat(rd_dat), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Single-port synchronous RAM, read-before-write, with a bench preload port
    bit [7:0] tb_mem [1024];
    always @(posedge clk) begin
        if (pl_en)
            tb_mem[pl_addr] <= pl_dat;
        else if (ram_we)
            tb_mem[ram_addr] <= ram_din;
        ram_dout <= tb_mem[ram_addr];
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [2:0] oh(input int w);
        logic [2:0] one;
        one = 3'b001;
        return (w < 0) ? 3'b000 : (one << w);
    endfunction

    // Reference model: requester 0=SS, 1=PPU, 2=CPU. Each grant schedules its
    // ack one slot ahead and its read data two slots ahead.
    bit [7:0]   m_mem [1024];
    int         e_ack [4];
    int         e_rv  [4];
    logic [7:0] e_dat [4];
    logic       e_we  [4];
    logic [9:0] e_addr[4];
    logic [7:0] e_din [4];
    int         m_wait = 0;
    int         cyc = 0;
    int         rst_seen = 0;
    int         s, ak, win, best, n1, n2;
    int         rank [3];
    bit         el [3];
    bit         promo, wr_ok, rq_we;
    logic [9:0] rq_addr;
    logic [7:0] rq_wdat;

    initial begin
        for (int i = 0; i < 4; i++) begin
            e_ack[i] = -1; e_rv[i] = -1; e_we[i] = 1'b0;
            e_dat[i] = '0; e_addr[i] = '0; e_din[i] = '0;
        end
    end

    always @(negedge clk) begin
        if (pl_en)
            m_mem[pl_addr] = pl_dat;
        s = cyc % 4;
        if (!map_rst_n || rst_seen != rst_pulses) begin
            rst_seen = rst_pulses;
            for (int i = 0; i < 4; i++) begin
                e_ack[i] = -1; e_rv[i] = -1; e_we[i] = 1'b0;
            end
            m_wait = 0;
            chk("reset_ram_addr", 32'(ram_addr), 0);
            chk("reset_ram_din", 32'(ram_din), 0);
            chk("reset_rd_dat", 32'(rd_dat), 0);
        end
        ak = e_ack[s];
        chk("acks", 32'({cpu_ack, ppu_ack, ss_ack}), 32'(oh(ak)));
        chk("rvalids", 32'({cpu_rvalid, ppu_rvalid, ss_rvalid}), 32'(oh(e_rv[s])));
        if (e_rv[s] >= 0)
            chk("rd_dat", 32'(rd_dat), 32'(e_dat[s]));
        chk("ram_we", 32'(ram_we), 32'(e_we[s]));
        if (ak >= 0) begin
            chk("ram_addr", 32'(ram_addr), 32'(e_addr[s]));
            chk("ram_din", 32'(ram_din), 32'(e_din[s]));
        end
        chk("wait_ctr", 32'(dut.wait_ctr), 32'(m_wait));
        e_ack[s] = -1; e_rv[s] = -1; e_we[s] = 1'b0;

        if (map_rst_n) begin
            el[0] = ss_act && ss_req && ak != 0;
            el[1] = !ss_act && ppu_req && ak != 1;
            el[2] = !ss_act && cpu_req && ak != 2;
            promo = (m_wait >= MAXW);
            rank[0] = 0;
            rank[1] = promo ? 2 : 1;
            rank[2] = promo ? 1 : 2;
            win = -1;
            best = 99;
            for (int i = 0; i < 3; i++)
                if (el[i] && rank[i] < best) begin
                    best = rank[i];
                    win = i;
                end
            if (!ss_act) begin
                if (!cpu_req || win == 2)
                    m_wait = 0;
                else if (el[2] && m_wait < MAXW)
                    m_wait++;
            end
            if (win >= 0) begin
                case (win)
                    0:       begin rq_we = ss_we;  rq_addr = ss_addr;  rq_wdat = ss_wdat;  end
                    1:       begin rq_we = ppu_we; rq_addr = ppu_addr; rq_wdat = ppu_wdat; end
                    default: begin rq_we = cpu_we; rq_addr = cpu_addr; rq_wdat = cpu_wdat; end
                endcase
                wr_ok = (win == 0) || (win == 1 && !exram_mode[1]) || (win == 2 && exram_mode != 2'd3);
                n1 = (cyc + 1) % 4;
                n2 = (cyc + 2) % 4;
                e_ack[n1]  = win;
                e_addr[n1] = rq_addr;
                e_din[n1]  = rq_wdat;
                e_we[n1]   = rq_we && wr_ok;
                if (rq_we) begin
                    if (wr_ok)
                        m_mem[rq_addr] = rq_wdat;
                end else begin
                    e_rv[n2]  = win;
                    e_dat[n2] = (win == 2 && !exram_mode[1]) ? 8'h00 : m_mem[rq_addr];
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_dat  = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    // Raise a request, hold it until its ack is seen, then drop it in the ack cycle.
    task automatic do_req(input int who, input logic we, input logic [9:0] a,
                          input logic [7:0] d, output int n);
        logic got;
        case (who)
            0:       begin ss_we = we;  ss_addr = a;  ss_wdat = d;  ss_req = 1'b1;  end
            1:       begin ppu_we = we; ppu_addr = a; ppu_wdat = d; ppu_req = 1'b1; end
            default: begin cpu_we = we; cpu_addr = a; cpu_wdat = d; cpu_req = 1'b1; end
        endcase
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            got = (who == 0) ? ss_ack : (who == 1) ? ppu_ack : cpu_ack;
        end
        if (!got)
            chk("ack_timeout", 32'(got), 1);
        ss_req  = (who == 0) ? 1'b0 : ss_req;
        ppu_req = (who == 1) ? 1'b0 : ppu_req;
        cpu_req = (who == 2) ? 1'b0 : cpu_req;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nss, np, nc;
        logic got_p, got_c;
        map_rst_n = 1'b0;
        exram_mode = 2'd2;
        ss_act = 0; ss_req = 0; ss_we = 0; ss_addr = '0; ss_wdat = '0;
        ppu_req = 0; ppu_we = 0; ppu_addr = '0; ppu_wdat = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdat = '0;
        repeat (2) tick();
        preload(10'h155, 8'h5A);
        preload(10'h000, 8'h11);
        preload(10'h001, 8'h22);
        preload(10'h010, 8'h33);
        preload(10'h020, 8'h3C);
        preload(10'h021, 8'hC3);
        chk("reset_acks", 32'({ss_ack, ppu_ack, cpu_ack, ram_we}), 0);
        map_rst_n = 1'b1;

        // single CPU read, mode 2
        do_req(2, 1'b0, 10'h155, 8'h00, n);
        chk("t1_ack_latency", 32'(n), 1);
        chk("t1_other_acks", 32'({ss_ack, ppu_ack}), 0);
        tick();
        chk("t1_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("t1_rd_dat", 32'(rd_dat), 32'h5A);
        repeat (2) tick();

        // continuous PPU traffic with a CPU request arriving alongside
        ppu_we = 0; ppu_addr = 10'h020; ppu_req = 1'b1;
        cpu_we = 0; cpu_addr = 10'h021; cpu_req = 1'b1;
        n = 0;
        got_c = 1'b0;
        while (!got_c && n < 12) begin
            tick();
            n++;
            got_c = cpu_ack;
        end
        cpu_req = 1'b0;
        chk("t2_cpu_granted", 32'(got_c), 1);
        chk("t2_cpu_wait_le7", 32'(n <= 7), 1);
        np = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            np += int'(ppu_ack);
        end
        ppu_req = 1'b0;
        chk("t2_ppu_alternate", 32'(np), 2);
        repeat (3) tick();
        chk("t2_wait_ctr_zero", 32'(dut.wait_ctr), 0);

        // save-state session freezes PPU/CPU and the wait counter
        ppu_addr = 10'h020; ppu_req = 1'b1;
        cpu_addr = 10'h021; cpu_req = 1'b1;
        tick();
        ss_act = 1'b1; ss_we = 1'b0; ss_addr = 10'h155; ss_req = 1'b1;
        chk("t3_ctr_before_ss", 32'(dut.wait_ctr), 1);
        nss = 0; np = 0; nc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            nss += int'(ss_ack);
            np  += int'(ppu_ack);
            nc  += int'(cpu_ack);
            if (i == 3)
                chk("t3_ctr_frozen", 32'(dut.wait_ctr), 1);
        end
        ss_act = 1'b0;
        ss_req = 1'b0;
        chk("t3_ss_acks", 32'(nss), 3);
        chk("t3_ppu_cpu_blocked", 32'(np + nc), 0);
        got_p = 1'b0; got_c = 1'b0;
        for (int i = 0; i < 10 && !(got_p && got_c); i++) begin
            tick();
            if (ppu_ack) begin got_p = 1'b1; ppu_req = 1'b0; end
            if (cpu_ack) begin got_c = 1'b1; cpu_req = 1'b0; end
        end
        ppu_req = 1'b0;
        cpu_req = 1'b0;
        chk("t3_ppu_after_ss", 32'(got_p), 1);
        chk("t3_cpu_after_ss", 32'(got_c), 1);
        repeat (3) tick();

        // mode gating
        exram_mode = 2'd3;
        do_req(2, 1'b1, 10'h010, 8'hAA, n);
        chk("t4_cpu_wr_mode3_we", 32'(ram_we), 0);
        repeat (2) tick();
        exram_mode = 2'd2;
        do_req(2, 1'b0, 10'h010, 8'h00, n);
        exram_mode = 2'd0;
        tick();
        chk("t4_readback_rvalid", 32'(cpu_rvalid), 1);
        chk("t4_readback_old", 32'(rd_dat), 32'h33);
        tick();
        do_req(2, 1'b0, 10'h155, 8'h00, n);
        tick();
        chk("t4_mode0_rvalid", 32'(cpu_rvalid), 1);
        chk("t4_mode0_zero", 32'(rd_dat), 0);
        tick();
        exram_mode = 2'd2;
        do_req(1, 1'b1, 10'h011, 8'h77, n);
        chk("t4_ppu_wr_mode2_we", 32'(ram_we), 0);
        tick();
        exram_mode = 2'd0;
        do_req(1, 1'b1, 10'h012, 8'h77, n);
        chk("t4_ppu_wr_mode0_we", 32'(ram_we), 1);
        chk("t4_ppu_wr_addr", 32'(ram_addr), 32'h012);
        chk("t4_ppu_wr_din", 32'(ram_din), 32'h77);
        tick();
        exram_mode = 2'd2;
        do_req(2, 1'b1, 10'h013, 8'h44, n);
        chk("t4_cpu_wr_mode2_we", 32'(ram_we), 1);
        tick();
        do_req(1, 1'b0, 10'h013, 8'h00, n);
        tick();
        chk("t4_ppu_readback", 32'(rd_dat), 32'h44);
        tick();
        exram_mode = 2'd3;
        ss_act = 1'b1;
        do_req(0, 1'b1, 10'h014, 8'h99, n);
        chk("t4_ss_wr_mode3_we", 32'(ram_we), 1);
        ss_act = 1'b0;
        exram_mode = 2'd2;
        repeat (2) tick();

        // back-to-back reads from different requesters
        ppu_we = 0; ppu_addr = 10'h000; ppu_req = 1'b1;
        cpu_we = 0; cpu_addr = 10'h001; cpu_req = 1'b1;
        tick();
        chk("t5_ppu_ack", 32'(ppu_ack), 1);
        ppu_req = 1'b0;
        tick();
        chk("t5_cpu_ack", 32'(cpu_ack), 1);
        chk("t5_ppu_rvalid", 32'(ppu_rvalid), 1);
        chk("t5_ppu_data", 32'(rd_dat), 32'h11);
        cpu_req = 1'b0;
        tick();
        chk("t5_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("t5_cpu_data", 32'(rd_dat), 32'h22);
        repeat (2) tick();

        // reset pulse while a PPU read is in flight
        do_req(1, 1'b0, 10'h000, 8'h00, n);
        map_rst_n = 1'b0;
        rst_pulses++;
        #2;
        map_rst_n = 1'b1;
        chk("t6_outputs_cleared",
            32'({ss_ack, ppu_ack, cpu_ack, ss_rvalid, ppu_rvalid, cpu_rvalid, ram_we}), 0);
        chk("t6_ram_addr_cleared", 32'(ram_addr), 0);
        np = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            np += int'(ppu_rvalid);
        end
        chk("t6_no_stale_rvalid", 32'(np), 0);
        do_req(2, 1'b0, 10'h001, 8'h00, n);
        chk("t6_ack_latency", 32'(n), 1);
        tick();
        chk("t6_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("t6_cpu_data", 32'(rd_dat), 32'h22);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmc5_xram_arb.md
Name: mmc5_xram_arb

Overview:
Arbiter/sequencer for the MMC5 1KB ExRAM, built as a single-port synchronous RAM shared by three requesters: save-state engine, PPU nametable/split fetch path and CPU $5C00-$5FFF window.
- Grants at most one access per clk.
- Applies exram_mode access rules.
- Returns read data with fixed latency and per-requester valid strobes.
- Sits between the mapper's bus decode and the RAM macro, replacing the dual-port xram.

Parameters:
CPU_MAX_WAIT, 6, clk cycles a pending CPU request may lose to PPU before it is promoted above PPU.
AW, 10, ExRAM address width.

Ports:
clk  in  1  system clock; all logic on rising edge
map_rst_n  in  1  asynchronous active-low reset
exram_mode  in  2  ExRAM mode ($5104)
ss_act  in  1  save-state session active
ss_req  in  1  save-state access request (level, held until ack)
ss_we  in  1  1=write
ss_addr  in  AW  save-state address
ss_wdat  in  8  save-state write data
ss_ack  out  1  one-cycle grant acknowledge
ss_rvalid  out  1  read data valid for save-state
ppu_req  in  1  PPU request
ppu_we  in  1  1=write
ppu_addr  in  AW  PPU address
ppu_wdat  in  8  PPU write data
ppu_ack  out  1  grant acknowledge
ppu_rvalid  out  1  read data valid for PPU
cpu_req  in  1  CPU request
cpu_we  in  1  1=write
cpu_addr  in  AW  CPU address
cpu_wdat  in  8  CPU write data
cpu_ack  out  1  grant acknowledge
cpu_rvalid  out  1  read data valid for CPU
rd_dat  out  8  shared read data, meaningful only with an rvalid
ram_addr  out  AW  RAM address (registered)
ram_we  out  1  RAM write enable (registered)
ram_din  out  8  RAM write data (registered)
ram_dout  in  8  RAM read data; valid the cycle after ram_addr is presented

Behaviour:
- Reset (async, map_rst_n=0):
  - All acks, rvalids and ram_we are 0.
  - ram_addr=0, ram_din=0, rd_dat=0.
  - Owner FSM goes to IDLE; wait counter=0; in-flight read tags are cleared. No rvalid appears after reset release for a read granted before reset.
- Owner FSM: states IDLE, OWN_SS, OWN_PPU, OWN_CPU.
  - State is the requester granted in the previous cycle.
  - It is IDLE when no grant was made.
- Eligibility per cycle:
  - A requester is eligible if its req=1 and its ack is not currently high. This blocks re-grant in the ack cycle; back-to-back grants to the same requester are at best every other cycle.
  - ss_act=1: only SS is eligible; PPU/CPU requests wait and the counter is frozen.
  - ss_act=0: ss_req is ignored.
- Priority: SS > PPU > CPU. Exception: CPU is placed above PPU when wait_ctr >= CPU_MAX_WAIT.
- wait_ctr:
  - Increments (saturating at CPU_MAX_WAIT) each cycle cpu_req=1, CPU is eligible and CPU is not granted.
  - Clears on CPU grant or when cpu_req=0.
- Grant timing:
  - Decision is made combinationally in cycle N.
  - In N+1: the granted ack=1 for exactly one cycle; ram_addr/ram_din reflect the request; ram_we per the rules below.
  - Reads: the matching rvalid=1 in N+2 with rd_dat=ram_dout (or forced 0, see below). Fixed 2-cycle grant-to-data latency.
- Mode rules:
  - CPU write with exram_mode=3: acked, ram_we=0.
  - CPU read with exram_mode[1]=0: acked, cpu_rvalid in N+2 with rd_dat=0x00.
  - PPU write with exram_mode[1]=1: acked, ram_we=0.
  - PPU read: allowed in all modes.
  - SS: always allowed regardless of mode.
  - A dropped access still consumes its slot.
- exram_mode is sampled in the grant cycle N. A mode change after N does not alter that access.
- Pipeline: a new grant may be issued every cycle. Overlapping reads from different requesters produce rvalids in grant order, one per cycle.
- ss_act falling while SS has an ack/rvalid in flight: the in-flight transfer completes normally.
- Simultaneous SS+PPU+CPU requests with ss_act=0: PPU wins; CPU waits (counter runs).

Test Plan:
- Reset then single CPU read: mode=2, cpu_req addr=0x155, RAM holds 0x5A → cpu_ack in cycle 1, cpu_rvalid in cycle 2 with rd_dat=0x5A; other acks 0.
- Continuous ppu_req with cpu_req pending, CPU_MAX_WAIT=6 → PPU granted in alternate slots; CPU granted no later than 7 cycles after cpu_req rises; wait_ctr returns to 0.
- ss_act=1 with ppu_req, cpu_req, ss_req all high → only ss_ack pulses; PPU/CPU acked only after ss_act drops, with wait_ctr unchanged during ss_act.
- Mode gating: mode=3 CPU write 0xAA to 0x010 → cpu_ack, ram_we=0, later read (mode=2) returns old value. Mode=0 CPU read → rd_dat=0x00 with cpu_rvalid. Mode=2 PPU write → ram_we=0.
- Back-to-back reads PPU@0x000 (data 0x11), CPU@0x001 (data 0x22), consecutive grants → ppu_rvalid/0x11 then cpu_rvalid/0x22 in consecutive cycles.
- map_rst_n pulsed low in the cycle after a PPU read ack → no ppu_rvalid; all outputs 0; FSM IDLE; next request follows normal latency.
